// File: rtl/vedic_divider_8bits.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
//
// Handshake: START is a request qualified only while the FSM is IDLE (BUSY=0
// and DONE=0). The edge that samples START=1 in IDLE accepts the operands A/B.
// DONE is a one-cycle pulse, with no back-pressure, that marks Q/R/DIV0 as
// valid. Those outputs then stay stable until the next accepted request loads
// a new result. START, A and B are ignored in CALC and FIN.
//
// Timing for B!=0 (t0 = accepting edge): BUSY is high for WIDTH cycles, and
// DONE is high in the cycle after edge t0+WIDTH.
// Timing for B=0: the divider goes straight to FIN. Q is all ones, R=A, and
// DONE is high in the cycle after t0.
module vedic_divider_8bits #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             DIV0,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // latched divisor
  logic [WIDTH:0]   rem_q, rem_d;     // partial remainder, one extra bit for the shift
  logic [CW-1:0]    cnt_q, cnt_d;     // iteration index within CALC
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic             q_bit;

  // One restoring step: shift {rem, dividend} left, then try to subtract the divisor.
  always_comb begin
    shifted  = (rem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    q_bit    = (shifted >= {1'b0, dvs_q});
    rem_next = q_bit ? (shifted - {1'b0, dvs_q}) : shifted;
    dvd_next = {dvd_q[WIDTH-2:0], q_bit};
  end

  // Next-state, datapath updates and status outputs.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            div0_d  = 1'b1;
            state_d = FIN;
          end else begin
            dvd_d   = A;
            dvs_d   = B;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        BUSY  = 1'b1;
        dvd_d = dvd_next;
        rem_d = rem_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          q_d     = dvd_next;
          r_d     = WIDTH'(rem_next);
          div0_d  = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset wins over any in-flight division.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      div0_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      r_q    <= r_d;
      div0_q <= div0_d;
    end
  end

  assign Q           = q_q;
  assign R           = r_q;
  assign DIV0        = div0_q;
  assign dbg_state_o = state_q;

endmodule
